// File: rtl/sram_line_adapter_if.sv
// Core-side bundle of sram_line_adapter: line request/response handshake plus
// the single-word preload port.
interface sram_line_adapter_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WIDTH = 128
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LINE_WIDTH-1:0] req_wdata;
  logic                  abort;
  logic                  resp_valid;
  logic [LINE_WIDTH-1:0] resp_rdata;
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [WORD_WIDTH-1:0] load_data;
  logic                  load_ack;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, abort, load_en, load_addr, load_data,
    input  req_ready, resp_valid, resp_rdata, load_ack
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, abort, load_en, load_addr, load_data,
    output req_ready, resp_valid, resp_rdata, load_ack
  );
endinterface

// File: rtl/sram_line_adapter.sv
// Splits core line requests into word beats on a single-port SRAM macro and
// reassembles read words into a line; also forwards preload word writes.
module sram_line_adapter #(
  parameter int ADDR_WIDTH      = 20,
  parameter int WORD_WIDTH      = 32,
  parameter int LINE_WIDTH      = 128,
  parameter int SRAM_RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_line_adapter_if.slave    bus,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [WORD_WIDTH-1:0] sram_din,
  input  logic [WORD_WIDTH-1:0] sram_dout
);
  localparam int BEATS = LINE_WIDTH / WORD_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAT   = SRAM_RD_LATENCY;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] base;
  logic [LINE_WIDTH-1:0] wline, rline, cap_line, resp_rdata;
  logic [BW-1:0]         beat, cap;
  logic [LAT:1]          vld_pipe;
  logic                  issue, capture, accept, last_beat, last_cap, kill;

  assign last_beat = (beat == LAST);
  assign last_cap  = (cap == LAST);
  assign issue     = (state == READ);
  assign kill      = bus.abort && (state != IDLE);
  // An abort discards the word arriving in the same cycle as well.
  assign capture   = vld_pipe[LAT] && !bus.abort;
  assign accept    = (state == IDLE) && bus.req_valid && bus.req_ready;
  assign bus.resp_rdata = resp_rdata;

  always_comb begin
    cap_line = rline;
    cap_line[cap*WORD_WIDTH +: WORD_WIDTH] = sram_dout;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n        = state;
    bus.req_ready  = 1'b0;
    bus.load_ack   = 1'b0;
    bus.resp_valid = 1'b0;
    sram_csb       = 1'b1;
    sram_web       = 1'b1;
    sram_addr      = '0;
    sram_din       = '0;
    case (state)
      IDLE: begin
        bus.req_ready = !bus.load_en;
        if (bus.load_en) begin
          if (!reset) begin
            sram_csb     = 1'b0;
            sram_web     = 1'b0;
            sram_addr    = bus.load_addr;
            sram_din     = bus.load_data;
            bus.load_ack = 1'b1;
          end
        end else if (bus.req_valid) begin
          state_n = bus.req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        sram_csb  = 1'b0;
        sram_web  = 1'b0;
        sram_addr = base + ADDR_WIDTH'(beat);
        sram_din  = wline[beat*WORD_WIDTH +: WORD_WIDTH];
        if (last_beat) state_n = DONE;
      end
      READ: begin
        sram_csb  = 1'b0;
        sram_addr = base + ADDR_WIDTH'(beat);
        if (last_beat) state_n = DRAIN;
      end
      DRAIN: if (capture && last_cap) state_n = DONE;
      DONE: begin
        bus.resp_valid = 1'b1;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (kill) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base       <= '0;
      wline      <= '0;
      rline      <= '0;
      resp_rdata <= '0;
      beat       <= '0;
      cap        <= '0;
      vld_pipe   <= '0;
    end else begin
      if (accept) begin
        base  <= bus.req_addr;
        wline <= bus.req_wdata;
        beat  <= '0;
        cap   <= '0;
      end else if (state == WRITE || state == READ) begin
        beat <= last_beat ? '0 : beat + 1'b1;
      end
      vld_pipe[1] <= issue;
      for (int k = 2; k <= LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
      if (capture) begin
        rline <= cap_line;
        cap   <= last_cap ? '0 : cap + 1'b1;
        if (last_cap) resp_rdata <= cap_line;
      end
      if (kill) begin
        beat     <= '0;
        cap      <= '0;
        vld_pipe <= '0;
      end
    end
  end
endmodule
